// File: rtl/rv4028_bus_target_if.sv
// RV4028 external bus signal bundle between the CPU (master) and one bus target (slave).
interface rv4028_bus_target_if;
  logic [31:0] addr;
  logic        req_n;
  logic        rd_n;
  logic        wr_n;
  logic [1:0]  msk_n;
  logic        iorq_n;
  logic [15:0] data_in;
  logic [15:0] data_out;
  logic        data_oe;
  logic        wait_n;
  logic        err;

  modport master (
    output addr, req_n, rd_n, wr_n, msk_n, iorq_n, data_in,
    input  data_out, data_oe, wait_n, err
  );

  modport slave (
    input  addr, req_n, rd_n, wr_n, msk_n, iorq_n, data_in,
    output data_out, data_oe, wait_n, err
  );
endinterface

// File: rtl/rv4028_bus_target.sv
// RV4028 bus target: decodes an address window and serves 16-bit byte-masked reads and
// writes from an internal word memory, stretching each access with wait_n.
// wait_n is low for the request cycle plus WAIT_STATES cycles in the wait state; read data
// is driven from the following cycle until req_n returns high.
// Optional feature: define RV4028_TARGET_POSTED_WRITE_EN to commit writes in the request
// cycle without wait states (reads are unaffected).
module rv4028_bus_target #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned ADDR_BITS   = 10,
  parameter int unsigned WAIT_STATES = 1,
  parameter bit          IO_SPACE    = 1'b0
) (
  input logic                clk,
  input logic                rst,
  rv4028_bus_target_if.slave bus
);

  localparam int unsigned IdxBits = ADDR_BITS - 1;
  localparam int unsigned Words   = 2 ** IdxBits;

  typedef enum logic [1:0] {StIdle, StWait, StData} state_e;

  state_e             state_q;
  logic [3:0]         cnt_q;
  logic [IdxBits-1:0] idx_q;
  logic               is_rd_q;
  logic [1:0]         msk_q;
  logic [15:0]        rdata_q;
  logic               data_oe_q;
  logic               err_q;

  // Word storage; deliberately not reset.
  logic [15:0] mem [Words];

  logic               sel;
  logic               rd_req;
  logic               wr_req;
  logic               both_low;
  logic [IdxBits-1:0] idx;
  logic               wait_n_c;
  logic               mem_we;
  logic [IdxBits-1:0] mem_widx;
  logic [1:0]         mem_wmsk_n;
  logic               unused_addr0;

  assign sel = !bus.req_n && (bus.iorq_n == !IO_SPACE) &&
               (bus.addr[31:ADDR_BITS] == BASE_ADDR[31:ADDR_BITS]);
  assign idx          = bus.addr[ADDR_BITS-1:1];
  assign rd_req       = sel && !bus.rd_n && bus.wr_n;
  assign wr_req       = sel && bus.rd_n && !bus.wr_n;
  assign both_low     = sel && !bus.rd_n && !bus.wr_n;
  assign unused_addr0 = bus.addr[0];

  // Wait request: combinational in idle so the CPU sees it in the request cycle,
  // state-only elsewhere. Held high while in reset.
  always_comb begin
    wait_n_c = 1'b1;
    unique case (state_q)
`ifdef RV4028_TARGET_POSTED_WRITE_EN
      StIdle:  wait_n_c = !(rd_req && !rst);
`else
      StIdle:  wait_n_c = !((rd_req || wr_req) && !rst);
`endif
      StWait:  wait_n_c = 1'b0;
      default: wait_n_c = 1'b1;
    endcase
  end

  assign bus.wait_n   = wait_n_c;
  assign bus.data_oe  = data_oe_q;
  assign bus.data_out = data_oe_q ? rdata_q : 16'h0000;
  assign bus.err      = err_q;

  // Memory write port selection: posted writes use live bus fields, delayed writes the
  // fields latched at accept.
  always_comb begin
    mem_we     = 1'b0;
    mem_widx   = idx_q;
    mem_wmsk_n = msk_q;
`ifdef RV4028_TARGET_POSTED_WRITE_EN
    if (state_q == StIdle && wr_req) begin
      mem_we     = 1'b1;
      mem_widx   = idx;
      mem_wmsk_n = bus.msk_n;
    end
`else
    if (state_q == StWait && !bus.req_n && cnt_q == 4'd0 && !is_rd_q) begin
      mem_we = 1'b1;
    end
`endif
  end

  // Byte-masked memory write; data_in is sampled on the commit edge.
  always_ff @(posedge clk) begin
    if (mem_we && !mem_wmsk_n[0]) mem[mem_widx][7:0]  <= bus.data_in[7:0];
    if (mem_we && !mem_wmsk_n[1]) mem[mem_widx][15:8] <= bus.data_in[15:8];
  end

  // Transaction FSM with registered data_oe, err and read data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      idx_q     <= '0;
      is_rd_q   <= 1'b0;
      msk_q     <= 2'b11;
      rdata_q   <= 16'h0000;
      data_oe_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (rd_req || wr_req) begin
            idx_q   <= idx;
            is_rd_q <= rd_req;
            msk_q   <= bus.msk_n;
            cnt_q   <= 4'(WAIT_STATES - 1);
            if (rd_req) rdata_q <= mem[idx];
`ifdef RV4028_TARGET_POSTED_WRITE_EN
            state_q <= rd_req ? StWait : StData;
`else
            state_q <= StWait;
`endif
          end else if (both_low) begin
            err_q <= 1'b1;
          end
        end
        StWait: begin
          if (bus.req_n) begin
            // Aborted by the master: drop the access and flag it.
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            err_q   <= 1'b1;
          end else if (cnt_q != 4'd0) begin
            cnt_q <= cnt_q - 4'd1;
          end else begin
            state_q   <= StData;
            data_oe_q <= is_rd_q;
          end
        end
        StData: begin
          if (bus.req_n) begin
            state_q   <= StIdle;
            data_oe_q <= 1'b0;
          end
        end
        default: begin
          state_q   <= StIdle;
          data_oe_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
